// File: rtl/calc_pkg.sv
// calc_pkg -- key codes, key count and debounce FSM encoding shared by the keypad front end.
// Rev 1.0
`default_nettype none

package calc_pkg;

  localparam int NUM_KEYS = 19;

  localparam logic [4:0] KEY_D0    = 5'd0;
  localparam logic [4:0] KEY_D1    = 5'd1;
  localparam logic [4:0] KEY_D2    = 5'd2;
  localparam logic [4:0] KEY_D3    = 5'd3;
  localparam logic [4:0] KEY_D4    = 5'd4;
  localparam logic [4:0] KEY_D5    = 5'd5;
  localparam logic [4:0] KEY_D6    = 5'd6;
  localparam logic [4:0] KEY_D7    = 5'd7;
  localparam logic [4:0] KEY_D8    = 5'd8;
  localparam logic [4:0] KEY_D9    = 5'd9;
  localparam logic [4:0] KEY_ADD   = 5'd10;
  localparam logic [4:0] KEY_SUB   = 5'd11;
  localparam logic [4:0] KEY_MUL   = 5'd12;
  localparam logic [4:0] KEY_DIV   = 5'd13;
  localparam logic [4:0] KEY_POWER = 5'd14;
  localparam logic [4:0] KEY_LOG   = 5'd15;
  localparam logic [4:0] KEY_EQUAL = 5'd16;
  localparam logic [4:0] KEY_CE    = 5'd17;
  localparam logic [4:0] KEY_AC    = 5'd18;

  // Bit 1 set means a key is down, so key_down can come straight off the state flop.
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_DEBOUNCE = 2'b01;
  localparam logic [1:0] ST_HELD     = 2'b10;
  localparam logic [1:0] ST_RELEASE  = 2'b11;

  function automatic logic [4:0] lowest_key(input logic [NUM_KEYS-1:0] keys);
    logic [4:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_sync2.sv
// key_sync2 -- two-flop synchronizer, async active-low reset to 0.
// Rev 1.0
`default_nettype none

module key_sync2 #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/keypad_debounce.sv
// keypad_debounce -- 19-key debouncer reporting the lowest pressed key once per press.
// Rev 1.0. Define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
`default_nettype none

module keypad_debounce
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] key_n,
  output logic        key_valid,
  output logic [4:0]  key_code,
  output logic        key_down
);

  localparam logic [15:0] c_DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] w_pressed;
  logic                w_cur_pressed;
  logic                w_rpt_fire;

  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic [4:0]  r_cur;
  logic        r_valid;
  logic [4:0]  r_code;

  key_sync2 #(
    .WIDTH (NUM_KEYS)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (~key_n),
    .o_q   (w_pressed)
  );

  assign w_cur_pressed = w_pressed[r_cur];

  if ((DEBOUNCE_CYCLES < 2) || (REPEAT_DELAY < 2) || (REPEAT_RATE < 2)) begin : g_param_range
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] c_DELAY_LAST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] c_RATE_LAST  = 16'(REPEAT_RATE - 1);

  logic [15:0] r_rpt;
  logic        r_rpt_armed;
  logic [15:0] w_rpt_limit;
  logic        w_rpt_run;

  // First interval uses the delay, every later one the rate.
  assign w_rpt_limit = r_rpt_armed ? c_RATE_LAST : c_DELAY_LAST;
  assign w_rpt_run   = (r_state == ST_HELD) && w_cur_pressed;
  assign w_rpt_fire  = w_rpt_run && (r_rpt == w_rpt_limit) &&
                       (r_cur != KEY_CE) && (r_cur != KEY_AC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rpt       <= '0;
      r_rpt_armed <= 1'b0;
    end else if (!w_rpt_run) begin
      r_rpt       <= '0;
      r_rpt_armed <= 1'b0;
    end else if (r_rpt == w_rpt_limit) begin
      r_rpt       <= '0;
      r_rpt_armed <= 1'b1;
    end else begin
      r_rpt <= r_rpt + 16'd1;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cur   <= '0;
      r_valid <= 1'b0;
      r_code  <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_pressed) begin
            r_cur   <= lowest_key(w_pressed);
            r_cnt   <= '0;
            r_state <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!w_cur_pressed) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == c_DEB_LAST) begin
            r_state <= ST_HELD;
            r_valid <= 1'b1;
            r_code  <= r_cur;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_HELD: begin
          if (!w_cur_pressed) begin
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end else if (w_rpt_fire) begin
            r_valid <= 1'b1;
            r_code  <= r_cur;
          end
        end
        ST_RELEASE: begin
          if (w_cur_pressed) begin
            r_state <= ST_HELD;
          end else if (r_cnt == c_DEB_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign key_down  = r_state[1];

endmodule

`default_nettype wire

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce -- directed checks of keypad_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=4.
// Rev 1.0
`default_nettype none

module tb_keypad_debounce;

`ifdef KEYPAD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [18:0] key_n;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_down;

  int n_vec;
  int n_err;

  keypad_debounce #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_RATE     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_n     (key_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #12;
    n_vec++;
    if ({key_valid, key_code, key_down} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b c=%0d d=%b want all 0", key_valid, key_code, key_down);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (key_valid !== 1'b0 || key_down !== 1'b0) begin
        n_err++;
        $display("FAIL idle_quiet edge %0d: got v=%b d=%b want 0 0", k, key_valid, key_down);
      end
    end
  endtask

  task automatic test_clean_press();
    logic exp_v, exp_d;
    for (int k = 1; k <= 30; k++) begin
      key_n = '1;
      if (k <= 20) key_n[5] = 1'b0;
      @(posedge clk); #1;
      exp_v = (k == 7) || (REP && (k == 15 || k == 19));
      exp_d = (k >= 7) && (k <= 26);
      n_vec++;
      if (key_valid !== exp_v) begin
        n_err++;
        $display("FAIL clean_valid edge %0d: got %b want %b", k, key_valid, exp_v);
      end
      n_vec++;
      if (key_down !== exp_d) begin
        n_err++;
        $display("FAIL clean_down edge %0d: got %b want %b", k, key_down, exp_d);
      end
      if (exp_v) begin
        n_vec++;
        if (key_code !== 5'd5) begin
          n_err++;
          $display("FAIL clean_code edge %0d: got %0d want 5", k, key_code);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic exp_v, exp_d;
    for (int k = 1; k <= 33; k++) begin
      key_n = '1;
      if (k <= 2 || (k >= 4 && k <= 23)) key_n[12] = 1'b0;
      @(posedge clk); #1;
      exp_v = (k == 10) || (REP && (k == 18 || k == 22));
      exp_d = (k >= 10) && (k <= 29);
      n_vec++;
      if (key_valid !== exp_v) begin
        n_err++;
        $display("FAIL bounce_valid edge %0d: got %b want %b", k, key_valid, exp_v);
      end
      n_vec++;
      if (key_down !== exp_d) begin
        n_err++;
        $display("FAIL bounce_down edge %0d: got %b want %b", k, key_down, exp_d);
      end
      if (exp_v) begin
        n_vec++;
        if (key_code !== 5'd12) begin
          n_err++;
          $display("FAIL bounce_code edge %0d: got %0d want 12", k, key_code);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic       exp_v, exp_d;
    logic [4:0] exp_c;
    for (int k = 1; k <= 50; k++) begin
      key_n = '1;
      if (k <= 10) key_n[3] = 1'b0;
      if (k <= 40) key_n[15] = 1'b0;
      @(posedge clk); #1;
      exp_v = (k == 7) || (k == 22) ||
              (REP && (k == 30 || k == 34 || k == 38 || k == 42));
      exp_d = ((k >= 7) && (k <= 16)) || ((k >= 22) && (k <= 46));
      exp_c = (k < 22) ? 5'd3 : 5'd15;
      n_vec++;
      if (key_valid !== exp_v) begin
        n_err++;
        $display("FAIL simul_valid edge %0d: got %b want %b", k, key_valid, exp_v);
      end
      n_vec++;
      if (key_down !== exp_d) begin
        n_err++;
        $display("FAIL simul_down edge %0d: got %b want %b", k, key_down, exp_d);
      end
      if (exp_v) begin
        n_vec++;
        if (key_code !== exp_c) begin
          n_err++;
          $display("FAIL simul_code edge %0d: got %0d want %0d", k, key_code, exp_c);
        end
      end
    end
  endtask

  task automatic test_release_chatter();
    logic exp_v, exp_d;
    for (int k = 1; k <= 40; k++) begin
      key_n = '1;
      if (k <= 14 || (k >= 17 && k <= 30)) key_n[9] = 1'b0;
      @(posedge clk); #1;
      exp_v = (k == 7) || (REP && (k == 15 || k == 27 || k == 31));
      exp_d = (k >= 7) && (k <= 36);
      n_vec++;
      if (key_valid !== exp_v) begin
        n_err++;
        $display("FAIL chatter_valid edge %0d: got %b want %b", k, key_valid, exp_v);
      end
      n_vec++;
      if (key_down !== exp_d) begin
        n_err++;
        $display("FAIL chatter_down edge %0d: got %b want %b", k, key_down, exp_d);
      end
      if (exp_v) begin
        n_vec++;
        if (key_code !== 5'd9) begin
          n_err++;
          $display("FAIL chatter_code edge %0d: got %0d want 9", k, key_code);
        end
      end
    end
  endtask

  task automatic test_repeat(input int key, input bit rep_ok);
    logic exp_v, exp_d;
    for (int k = 1; k <= 46; k++) begin
      key_n = '1;
      if (k <= 36) key_n[key] = 1'b0;
      @(posedge clk); #1;
      exp_v = (k == 7) ||
              (REP && rep_ok && (k >= 15) && (k <= 35) && ((k - 15) % 4 == 0));
      exp_d = (k >= 7) && (k <= 42);
      n_vec++;
      if (key_valid !== exp_v) begin
        n_err++;
        $display("FAIL repeat%0d_valid edge %0d: got %b want %b", key, k, key_valid, exp_v);
      end
      n_vec++;
      if (key_down !== exp_d) begin
        n_err++;
        $display("FAIL repeat%0d_down edge %0d: got %b want %b", key, k, key_down, exp_d);
      end
      if (exp_v) begin
        n_vec++;
        if (key_code !== 5'(key)) begin
          n_err++;
          $display("FAIL repeat%0d_code edge %0d: got %0d want %0d", key, k, key_code, key);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_v, exp_d;
    key_n = '1;
    key_n[2] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (key_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_pre edge %0d: got %b want 0", k, key_valid);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({key_valid, key_code, key_down} !== 7'b0) begin
      n_err++;
      $display("FAIL midrst_async: got v=%b c=%0d d=%b want all 0", key_valid, key_code, key_down);
    end
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({key_valid, key_code, key_down} !== 7'b0) begin
        n_err++;
        $display("FAIL midrst_hold edge %0d: got v=%b c=%0d d=%b want all 0", k, key_valid, key_code, key_down);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      key_n = '1;
      if (k <= 10) key_n[2] = 1'b0;
      @(posedge clk); #1;
      exp_v = (k == 7);
      exp_d = (k >= 7) && (k <= 16);
      n_vec++;
      if (key_valid !== exp_v) begin
        n_err++;
        $display("FAIL midrst_valid edge %0d: got %b want %b", k, key_valid, exp_v);
      end
      n_vec++;
      if (key_down !== exp_d) begin
        n_err++;
        $display("FAIL midrst_down edge %0d: got %b want %b", k, key_down, exp_d);
      end
      if (exp_v) begin
        n_vec++;
        if (key_code !== 5'd2) begin
          n_err++;
          $display("FAIL midrst_code edge %0d: got %0d want 2", k, key_code);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clk   = 1'b0;
    reset = 1'b0;
    key_n = '1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_release_chatter();
    test_repeat(10, 1'b1);
    test_repeat(18, 1'b0);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
